// File: rtl/usb_reg_bank.sv
// rtl/usb_reg_bank.sv - packet-written register bank with MSB-first shadow load and readback
module usb_reg_bank #(
    parameter int             NUM_REGS  = 4,
    parameter int             REG_BYTES = 8,
    parameter logic [7:0]     BASE_ADDR = 8'h00,
    localparam int            IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int            RW        = REG_BYTES * 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             d,
    input  logic                   d_asserted,
    output logic [NUM_REGS*RW-1:0] q_all,
    output logic [NUM_REGS-1:0]    wr_stb,
    output logic                   err_addr,
    output logic                   err_len,
    output logic                   busy,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [RW-1:0]          rd_data
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;
    localparam int         CW     = $clog2(REG_BYTES + 2);
    localparam logic [8:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [8:0] ADDR_HI = ADDR_LO + 9'(NUM_REGS - 1);

    logic [0:0]          state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [RW-1:0]       shadow_q, shadow_d;
    logic [CW-1:0]       count_q, count_d;
    logic [RW-1:0]       regs_q [NUM_REGS];
    logic [RW-1:0]       regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
    logic                err_addr_q, err_addr_d;
    logic                err_len_q, err_len_d;
    logic [RW-1:0]       rd_data_q, rd_data_d;

    logic                addr_ok;
    logic [IDX_W-1:0]    idx;

    // 9-bit compare so BASE_ADDR+NUM_REGS-1 past 8'hFF cannot wrap
    assign addr_ok = ({1'b0, addr_q} >= ADDR_LO) && ({1'b0, addr_q} <= ADDR_HI);
    assign idx     = IDX_W'(addr_q - BASE_ADDR);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shadow_d   = shadow_q;
        count_d    = count_q;
        regs_d     = regs_q;
        wr_stb_d   = '0;
        err_addr_d = 1'b0;
        err_len_d  = 1'b0;
        rd_data_d  = '0;
        if (int'(rd_idx) < NUM_REGS) begin
            rd_data_d = regs_q[rd_idx];
        end

        case (state_q)
            S_IDLE: begin
                if (d_asserted) begin
                    addr_d   = d;
                    shadow_d = '0;
                    count_d  = '0;
                    state_d  = S_DATA;
                end
            end
            default: begin
                if (d_asserted) begin
                    for (int b = 0; b < REG_BYTES; b++) begin
                        if (count_q == CW'(b)) begin
                            shadow_d[RW-1-8*b -: 8] = d;
                        end
                    end
                    // Saturating one past full keeps overlong packets distinguishable
                    if (count_q != CW'(REG_BYTES + 1)) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (!addr_ok) begin
                        err_addr_d = 1'b1;
                    end else if (count_q == CW'(REG_BYTES)) begin
                        regs_d[idx]   = shadow_q;
                        wr_stb_d[idx] = 1'b1;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            shadow_q   <= '0;
            count_q    <= '0;
            wr_stb_q   <= '0;
            err_addr_q <= 1'b0;
            err_len_q  <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            shadow_q   <= shadow_d;
            count_q    <= count_d;
            wr_stb_q   <= wr_stb_d;
            err_addr_q <= err_addr_d;
            err_len_q  <= err_len_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        q_all = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            q_all[i*RW +: RW] = regs_q[i];
        end
    end

    assign wr_stb   = wr_stb_q;
    assign err_addr = err_addr_q;
    assign err_len  = err_len_q;
    assign busy     = (state_q == S_DATA);
    assign rd_data  = rd_data_q;
endmodule
